mips_alu: RTL and testbench
===========================

// Module: mips_alu
// PURPOSE
//   Registered 32-bit MIPS-subset ALU. Decodes one instruction word (R-type funct or I-type opcode).
//   Operands come from two register-value inputs; the rs/rt fields select between them.
//   Produces a result word and three status flags one clock after the inputs are sampled.
//   Sits in the execute stage between register read and memory/writeback.
// PARAMETERS
//   none (data width fixed at 32)
// PORTS
//   clk          in   1   clock, rising-edge
//   rst_n        in   1   synchronous active-low reset
//   instruction  in   32  instruction word
//   reg_A        in   32  register value A
//   reg_B        in   32  register value B
//   result       out  32  registered ALU result
//   flags        out  3   registered {zero, negative, overflow} = flags[2:0]
// BEHAVIOUR
// - One clock, synchronous active-low reset:
//   - posedge clk with rst_n=0: result<=0, flags<=0.
//   - Otherwise result and flags load the combinational outcome of the current inputs.
//   - Latency is exactly 1 cycle; no handshake; a new operation is accepted every cycle.
// - Operand select:
//   - rega = (instr[25:21]==0) ? reg_A : reg_B.
//   - regb = (instr[20:16]==0) ? reg_A : reg_B.
// - Immediate:
//   - simm = sign-extend instr[15:0]; zimm = zero-extend instr[15:0].
//   - shamt = instr[10:6].
// - op=000000 (R-type), funct instr[5:0]:
//   - 100000 add:  rega+regb, ovf.
//   - 100001 addu: rega+regb.
//   - 100010 sub:  rega-regb, ovf.
//   - 100011 subu: rega-regb.
//   - 100100 and, 100101 or, 100110 xor, 100111 nor (rega op regb).
//   - 101010 slt:  signed rega<regb ? 1 : 0.
//   - 101011 sltu: unsigned compare, same result encoding.
//   - 000000 sll: regb<<shamt; 000010 srl: regb>>shamt; 000011 sra: arithmetic regb>>>shamt.
//   - 000100 sllv / 000110 srlv / 000111 srav: same as above, shift amount = rega[4:0].
// - I-type:
//   - 001000 addi: rega+simm, ovf.
//   - 001001 addiu: rega+simm.
//   - 001100 andi / 001101 ori / 001110 xori: rega op zimm.
//   - 001010 slti: signed rega<simm. 001011 sltiu: unsigned rega<simm.
//   - 000100 beq / 000101 bne: result = rega-regb.
//   - 100011 lw / 101011 sw: result = rega+simm (address, wraps mod 2^32).
// - Flags (all others 0):
//   - overflow: only add/addi/sub. Set on signed overflow (operand signs agree, result sign differs;
//     for sub, use the sign of -regb). Result still holds the wrapped 32-bit sum/difference.
//   - zero: only beq/bne, set when rega==regb.
//   - negative: only slt/slti/sltu/sltiu, set when the compare is true (result==1).
// - Unsupported opcode/funct: result=0, flags=0.
// - Arithmetic is modulo 2^32; shift amounts use 5 bits only (0..31).
// TESTING
//   T1 add: instr=0x00010020, A=0x000000FF, B=0x00000001 -> result=0x00000100, flags=000.
//   T2 add ovf: same instr, A=0x80000000, B=0xFFFFFFF1 -> result=0x7FFFFFF1, flags=001.
//   T3 beq: instr=0x10210000 (rs=rt=1) -> result=0, flags=100; bne 0x14210000 -> same.
//   T4 slt: instr=0x0020002A, A=0x1FFFFEE2, B=0xFDDD2222 -> result=1, flags=010.
//   T5 sra: instr=0x000080C3, A=0x80FFFEE2 -> result=0xF01FFFDC, flags=000.
//      srl with same operands -> result=0x101FFFDC.
//   T6 reset: hold rst_n=0 while driving T2 -> result=0, flags=000 after the edge.
//      Release rst_n -> T2 values appear 1 cycle later.

Source files
------------

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - registered 32-bit MIPS-subset execute-stage ALU
module mips_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] reg_A,
  input  logic [31:0] reg_B,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  shamt;
  logic [31:0] rega;
  logic [31:0] regb;
  logic [31:0] simm;
  logic [31:0] zimm;
  logic [31:0] nregb;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] isum;
  logic        lt_s;
  logic        lt_u;
  logic        lti_s;
  logic        lti_u;
  logic [31:0] nxt_result;
  logic [2:0]  nxt_flags;

  assign op    = instruction[31:26];
  assign funct = instruction[5:0];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign shamt = instruction[10:6];

  // Register fields only steer between the two read ports; zero picks port A.
  assign rega = (rs == 5'd0) ? reg_A : reg_B;
  assign regb = (rt == 5'd0) ? reg_A : reg_B;

  assign simm  = {{16{instruction[15]}}, instruction[15:0]};
  assign zimm  = {16'd0, instruction[15:0]};
  assign nregb = ~regb + 32'd1;
  assign sum   = rega + regb;
  assign diff  = rega - regb;
  assign isum  = rega + simm;

  assign lt_s  = $signed(rega) < $signed(regb);
  assign lt_u  = rega < regb;
  assign lti_s = $signed(rega) < $signed(simm);
  assign lti_u = rega < simm;

  // Subtraction overflow is judged as the addition of rega and -regb.
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  always_comb begin
    nxt_result = 32'd0;
    nxt_flags  = 3'b000;
    if (op == 6'b000000) begin
      case (funct)
        6'b100000: begin
          nxt_result   = sum;
          nxt_flags[0] = add_ovf(rega, regb, sum);
        end
        6'b100001: nxt_result = sum;
        6'b100010: begin
          nxt_result   = diff;
          nxt_flags[0] = add_ovf(rega, nregb, diff);
        end
        6'b100011: nxt_result = diff;
        6'b100100: nxt_result = rega & regb;
        6'b100101: nxt_result = rega | regb;
        6'b100110: nxt_result = rega ^ regb;
        6'b100111: nxt_result = ~(rega | regb);
        6'b101010: begin
          nxt_result   = {31'd0, lt_s};
          nxt_flags[1] = lt_s;
        end
        6'b101011: begin
          nxt_result   = {31'd0, lt_u};
          nxt_flags[1] = lt_u;
        end
        6'b000000: nxt_result = regb << shamt;
        6'b000010: nxt_result = regb >> shamt;
        6'b000011: nxt_result = $signed(regb) >>> shamt;
        6'b000100: nxt_result = regb << rega[4:0];
        6'b000110: nxt_result = regb >> rega[4:0];
        6'b000111: nxt_result = $signed(regb) >>> rega[4:0];
        default:   nxt_result = 32'd0;
      endcase
    end else begin
      case (op)
        6'b001000: begin
          nxt_result   = isum;
          nxt_flags[0] = add_ovf(rega, simm, isum);
        end
        6'b001001: nxt_result = isum;
        6'b001100: nxt_result = rega & zimm;
        6'b001101: nxt_result = rega | zimm;
        6'b001110: nxt_result = rega ^ zimm;
        6'b001010: begin
          nxt_result   = {31'd0, lti_s};
          nxt_flags[1] = lti_s;
        end
        6'b001011: begin
          nxt_result   = {31'd0, lti_u};
          nxt_flags[1] = lti_u;
        end
        6'b000100, 6'b000101: begin
          nxt_result   = diff;
          nxt_flags[2] = (rega == regb);
        end
        6'b100011, 6'b101011: nxt_result = isum;
        default: nxt_result = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= 32'd0;
      flags  <= 3'b000;
    end else begin
      result <= nxt_result;
      flags  <= nxt_flags;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - scoreboard bench for mips_alu with a behavioural reference model
module tb_mips_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] reg_A;
  logic [31:0] reg_B;
  logic [31:0] result;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  mips_alu dut (
    .clk(clk),
    .rst_n(rst_n),
    .instruction(instruction),
    .reg_A(reg_A),
    .reg_B(reg_B),
    .result(result),
    .flags(flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic out_of_range(input longint x);
    return (x > 64'sh000000007FFFFFFF) || (x < -64'sh0000000080000000);
  endfunction

  // Reference: operands as mathematical integers, results reduced mod 2^32.
  function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic [2:0] f);
    logic [31:0] ra, rb, sx, nrb;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    longint      sa, sbv, ua, ub, simm, usimm, zimm, t;
    logic        z, n, v;
    ra    = (ins[25:21] == 5'd0) ? a : b;
    rb    = (ins[20:16] == 5'd0) ? a : b;
    op    = ins[31:26];
    fn    = ins[5:0];
    sh    = ins[10:6];
    sa    = longint'($signed(ra));
    sbv   = longint'($signed(rb));
    ua    = longint'(ra);
    ub    = longint'(rb);
    sx    = {{16{ins[15]}}, ins[15:0]};
    simm  = longint'($signed(sx));
    usimm = longint'(sx);
    zimm  = longint'(ins[15:0]);
    nrb   = 32'(-sbv);
    z = 1'b0; n = 1'b0; v = 1'b0; r = 32'd0;
    if (op == 6'd0) begin
      case (fn)
        6'h20: begin t = sa + sbv; r = 32'(t); v = out_of_range(t); end
        6'h21: r = 32'(ua + ub);
        6'h22: begin r = 32'(sa - sbv); v = out_of_range(sa + longint'($signed(nrb))); end
        6'h23: r = 32'(ua - ub);
        6'h24: r = 32'(ua & ub);
        6'h25: r = 32'(ua | ub);
        6'h26: r = 32'(ua ^ ub);
        6'h27: r = 32'(~(ua | ub));
        6'h2A: begin n = (sa < sbv); r = n ? 32'd1 : 32'd0; end
        6'h2B: begin n = (ua < ub);  r = n ? 32'd1 : 32'd0; end
        6'h00: r = 32'(ub * (64'd1 << sh));
        6'h02: r = 32'(ub / (64'd1 << sh));
        6'h03: r = 32'(sbv >>> sh);
        6'h04: r = 32'(ub * (64'd1 << ra[4:0]));
        6'h06: r = 32'(ub / (64'd1 << ra[4:0]));
        6'h07: r = 32'(sbv >>> ra[4:0]);
        default: r = 32'd0;
      endcase
    end else begin
      case (op)
        6'h08: begin t = sa + simm; r = 32'(t); v = out_of_range(t); end
        6'h09: r = 32'(sa + simm);
        6'h0C: r = 32'(ua & zimm);
        6'h0D: r = 32'(ua | zimm);
        6'h0E: r = 32'(ua ^ zimm);
        6'h0A: begin n = (sa < simm);  r = n ? 32'd1 : 32'd0; end
        6'h0B: begin n = (ua < usimm); r = n ? 32'd1 : 32'd0; end
        6'h04, 6'h05: begin r = 32'(sa - sbv); z = (sa == sbv); end
        6'h23, 6'h2B: r = 32'(sa + simm);
        default: r = 32'd0;
      endcase
    end
    f = {z, n, v};
  endfunction

  task automatic issue(input logic rst, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    instruction = ins;
    reg_A       = a;
    reg_B       = b;
    if (rst) model(ins, a, b, e.res, e.flg);
    else begin
      e.res = 32'd0;
      e.flg = 3'b000;
    end
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 1) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  function automatic logic [31:0] pick_instr();
    logic [5:0] rfn[17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01};
    logic [5:0] iop[13] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h04,
                            6'h05, 6'h23, 6'h2B, 6'h02, 6'h3F};
    logic [15:0] imm;
    imm = 16'($urandom);
    if ($urandom_range(0, 1) == 0)
      return {6'd0, pick_reg(), pick_reg(), 5'($urandom), 5'($urandom),
              rfn[$urandom_range(0, 16)]};
    return {iop[$urandom_range(0, 12)], pick_reg(), pick_reg(), imm};
  endfunction

  exp_t m;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        m = sb.pop_front();
        n_checks++;
        if (result !== m.res || flags !== m.flg) begin
          n_fail++;
          $display("FAIL %s: got result=%h flags=%b, want result=%h flags=%b",
                   m.tag, result, flags, m.res, m.flg);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    instruction = 32'd0;
    reg_A       = 32'd0;
    reg_B       = 32'd0;
    issue(1'b0, 32'h0000_0000, 32'h0, 32'h0, "reset_state");
    issue(1'b1, 32'h0001_0020, 32'h0000_00FF, 32'h0000_0001, "t1_add");
    issue(1'b1, 32'h0001_0020, 32'h8000_0000, 32'hFFFF_FFF1, "t2_add_ovf");
    issue(1'b1, 32'h1021_0000, 32'h1234_5678, 32'h9ABC_DEF0, "t3_beq");
    issue(1'b1, 32'h1421_0000, 32'h1234_5678, 32'h9ABC_DEF0, "t3_bne");
    issue(1'b1, 32'h0020_002A, 32'h1FFF_FEE2, 32'hFDDD_2222, "t4_slt");
    issue(1'b1, 32'h0000_80C3, 32'h80FF_FEE2, 32'h0000_0000, "t5_sra");
    issue(1'b1, 32'h0000_80C2, 32'h80FF_FEE2, 32'h0000_0000, "t5_srl");
    issue(1'b0, 32'h0001_0020, 32'h8000_0000, 32'hFFFF_FFF1, "t6_reset_hold");
    issue(1'b0, 32'h0001_0020, 32'h8000_0000, 32'hFFFF_FFF1, "t6_reset_hold2");
    issue(1'b1, 32'h0001_0020, 32'h8000_0000, 32'hFFFF_FFF1, "t6_release");
    issue(1'b1, 32'h0001_0022, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "sub_ovf");
    issue(1'b1, 32'h2000_8000, 32'h8000_0000, 32'h0, "addi_ovf_neg_imm");
    issue(1'b1, 32'h2C00_FFFF, 32'h0000_0005, 32'h0, "sltiu_sx_imm");
    issue(1'b1, 32'h0000_07C0, 32'hFFFF_FFFF, 32'h0, "sll_31");
    issue(1'b1, 32'hFC00_0000, 32'h1111_1111, 32'h2222_2222, "unsupported_op");
    issue(1'b1, 32'h0000_0001, 32'h1111_1111, 32'h2222_2222, "unsupported_funct");
    for (int i = 0; i < 800; i++) begin
      issue(($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1, pick_instr(), pick_val(),
            pick_val(), $sformatf("rnd%0d", i));
    end
    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d outstanding expectations, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
